// File: rtl/fifo_axis_packer_if.sv
// Bus bundle for fifo_axis_packer: the FIFO read port, the flush request and the
// AXI4-Stream master beat. The packer connects through "master"; whatever surrounds
// it (FIFO plus downstream sink, or a bench) connects through "slave".
interface fifo_axis_packer_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic             rd_empty;
  logic [W-1:0]     rd_data;
  logic             rd_en;
  logic             flush;
  logic [N*W-1:0]   m_tdata;
  logic [N-1:0]     m_tkeep;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;

  modport master (
    input  rd_empty, rd_data, flush, m_tready,
    output rd_en, m_tdata, m_tkeep, m_tlast, m_tvalid
  );

  modport slave (
    output rd_empty, rd_data, flush, m_tready,
    input  rd_en, m_tdata, m_tkeep, m_tlast, m_tvalid
  );
endinterface

// File: rtl/fifo_axis_packer.sv
// Drains a W-bit FIFO read port and packs N consecutive words into one N*W-bit
// AXI4-Stream beat. A flush pulse closes a partial beat with tkeep marking the
// filled lanes and tlast set. One output register slot decouples the accumulator
// from downstream backpressure.
module fifo_axis_packer #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_axis_packer_if.master  bus
);

  localparam int CW = $clog2(N + 1);
  localparam int AW = N * W;

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          flush_pend;

  logic [AW-1:0] tdata_q;
  logic [N-1:0]  tkeep_q;
  logic          tlast_q;
  logic          tvalid_q;

  logic          slot_free;
  logic          beat_ready;
  logic          xfer;
  logic          pop;
  logic [N-1:0]  keep_mask;
  logic [AW-1:0] data_mask;

  // Transfer/pop decisions and the lane mask for the beat being closed.
  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    keep_mask  = '0;
    data_mask  = '0;
    slot_free  = ~tvalid_q | bus.m_tready;
    beat_ready = (cnt == CW'(N)) | (flush_pend & (cnt != '0));
    xfer       = beat_ready & slot_free;
    // A completing beat may hand over and accept a new word in the same cycle,
    // which is what keeps the stream at one word per clock.
    pop        = ~reset & ~bus.rd_empty & ~flush_pend & ((cnt < CW'(N)) | xfer);
    for (int k = 0; k < N; k++) begin
      keep_mask[k]         = (CW'(k) < cnt);
      data_mask[k*W +: W]  = {W{keep_mask[k]}};
    end
  end

  // Accumulator and lane counter: clear on handover, append the popped word.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (xfer) begin
      // The word popped alongside a handover starts the next beat in lane 0.
      acc <= pop ? AW'(bus.rd_data) : '0;
      cnt <= pop ? CW'(1) : '0;
    end else if (pop) begin
      for (int k = 0; k < N; k++) begin
        if (cnt == CW'(k)) acc[k*W +: W] <= bus.rd_data;
      end
      cnt <= cnt + CW'(1);
    end
  end

  // Pending flush: held until its beat hands over, or dropped if nothing is buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pend <= 1'b0;
    end else if (flush_pend) begin
      // A repeat flush while one is pending merges into it.
      if (xfer | (cnt == '0)) flush_pend <= 1'b0;
    end else if (bus.flush) begin
      flush_pend <= 1'b1;
    end
  end

  // Output slot: load on handover, drop valid once accepted, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (xfer) begin
      tdata_q  <= acc & data_mask;
      tkeep_q  <= keep_mask;
      tlast_q  <= flush_pend;
      tvalid_q <= 1'b1;
    end else if (bus.m_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign bus.rd_en    = pop;
  assign bus.m_tdata  = tdata_q;
  assign bus.m_tkeep  = tkeep_q;
  assign bus.m_tlast  = tlast_q;
  assign bus.m_tvalid = tvalid_q;

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Self-checking bench for fifo_axis_packer (W=8, N=4). A queue models the upstream
// FIFO; accepted beats are collected and compared against hand-computed values,
// then a long random run checks the packed stream against the popped words.
module tb_fifo_axis_packer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int          nw;
    logic [31:0] words;
    bit          do_flush;
    int          exp_beats;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
  } vec_t;

  logic clk;
  logic reset;

  fifo_axis_packer_if #(.W(8), .N(4)) intf ();

  fifo_axis_packer #(.W(8), .N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         pops = 0;
  logic       last_rd_en = 1'b0;
  logic       prev_stall = 1'b0;
  beat_t      prev_beat;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  beat_t      rx[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    intf.rd_empty = (q.size() == 0);
    intf.rd_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: sample on the falling edge, then update the FIFO model after the rising edge.
  task automatic tick();
    logic popped;
    @(negedge clk);
    last_rd_en = intf.rd_en;
    check("rd_en_while_empty", intf.rd_en & intf.rd_empty, 1'b0);
    if (prev_stall) begin
      check("stall_valid", intf.m_tvalid, 1'b1);
      check("stall_data", intf.m_tdata, prev_beat.data);
      check("stall_keep", intf.m_tkeep, prev_beat.keep);
      check("stall_last", intf.m_tlast, prev_beat.last);
    end
    if (intf.m_tvalid && intf.m_tready)
      rx.push_back('{data: intf.m_tdata, keep: intf.m_tkeep, last: intf.m_tlast});
    prev_stall = intf.m_tvalid & ~intf.m_tready;
    prev_beat  = '{data: intf.m_tdata, keep: intf.m_tkeep, last: intf.m_tlast};
    popped     = intf.rd_en;
    @(posedge clk);
    #1;
    if (popped && q.size() != 0) begin
      exp_q.push_back(q.pop_front());
      pops++;
    end
    refresh();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_model();
    q.delete();
    rx.delete();
    exp_q.delete();
    pops       = 0;
    prev_stall = 1'b0;
    refresh();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    intf.flush     = 1'b0;
    intf.m_tready  = 1'b0;
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    refresh();
  endtask

  task automatic check_beat(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    if (idx >= rx.size()) begin
      check({name, "_present"}, 0, 1);
    end else begin
      check({name, "_data"}, rx[idx].data, d);
      check({name, "_keep"}, rx[idx].keep, k);
      check({name, "_last"}, rx[idx].last, l);
    end
  endtask

  // Drains collected beats and compares lanes against the words popped so far.
  task automatic score();
    beat_t b;
    logic  legal;
    while (rx.size() != 0) begin
      b     = rx.pop_front();
      legal = (b.keep == 4'h1) || (b.keep == 4'h3) || (b.keep == 4'h7) || (b.keep == 4'hF);
      check("rand_keep_shape", legal, 1'b1);
      if (!b.last) check("rand_full_keep", b.keep, 4'hF);
      for (int k = 0; k < 4; k++) begin
        if (b.keep[k]) begin
          if (exp_q.size() == 0) check("rand_extra_word", 1, 0);
          else check("rand_lane_data", b.data[k*8 +: 8], exp_q.pop_front());
        end else begin
          check("rand_lane_zero", b.data[k*8 +: 8], 8'h00);
        end
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] word;

    vecs[0] = '{nw: 4, words: 32'h44332211, do_flush: 1'b0, exp_beats: 1,
                exp_data: 32'h44332211, exp_keep: 4'hF, exp_last: 1'b0};
    vecs[1] = '{nw: 2, words: 32'h0000A2A1, do_flush: 1'b1, exp_beats: 1,
                exp_data: 32'h0000A2A1, exp_keep: 4'h3, exp_last: 1'b1};
    vecs[2] = '{nw: 1, words: 32'h000000C1, do_flush: 1'b1, exp_beats: 1,
                exp_data: 32'h000000C1, exp_keep: 4'h1, exp_last: 1'b1};
    vecs[3] = '{nw: 3, words: 32'h00D3D2D1, do_flush: 1'b1, exp_beats: 1,
                exp_data: 32'h00D3D2D1, exp_keep: 4'h7, exp_last: 1'b1};
    vecs[4] = '{nw: 0, words: 32'h00000000, do_flush: 1'b1, exp_beats: 0,
                exp_data: 32'h0, exp_keep: 4'h0, exp_last: 1'b0};
    vecs[5] = '{nw: 3, words: 32'h00E3E2E1, do_flush: 1'b0, exp_beats: 0,
                exp_data: 32'h0, exp_keep: 4'h0, exp_last: 1'b0};

    reset         = 1'b1;
    intf.flush    = 1'b0;
    intf.m_tready = 1'b0;
    clear_model();

    // Reset state, with data waiting so rd_en has a reason to rise.
    push_words(8'h10, 1);
    #12;
    check("reset_tvalid", intf.m_tvalid, 1'b0);
    check("reset_tdata", intf.m_tdata, 32'h0);
    check("reset_tkeep", intf.m_tkeep, 4'h0);
    check("reset_tlast", intf.m_tlast, 1'b0);
    check("reset_rd_en", intf.rd_en, 1'b0);

    // Table: words popped back-to-back, optional flush in the last pop's cycle.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].nw; i++) q.push_back(vecs[v].words[i*8 +: 8]);
      refresh();
      intf.m_tready = 1'b1;
      for (int i = 0; i < vecs[v].nw; i++) begin
        intf.flush = vecs[v].do_flush && (i == vecs[v].nw - 1);
        tick();
        intf.flush = 1'b0;
      end
      check($sformatf("vec%0d_pops_b2b", v), pops, vecs[v].nw);
      if (vecs[v].nw == 0 && vecs[v].do_flush) begin
        intf.flush = 1'b1;
        tick();
        intf.flush = 1'b0;
      end
      ticks(8);
      check($sformatf("vec%0d_pops", v), pops, vecs[v].nw);
      check($sformatf("vec%0d_beats", v), rx.size(), vecs[v].exp_beats);
      if (vecs[v].exp_beats > 0)
        check_beat($sformatf("vec%0d", v), 0, vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last);
    end

    // Backpressure: 12 words, sink stalled 10 cycles.
    do_reset();
    push_words(8'h01, 12);
    ticks(10);
    check("bp_pops", pops, 8);
    check("bp_rd_en_low", last_rd_en, 1'b0);
    intf.m_tready = 1'b1;
    ticks(20);
    check("bp_beats", rx.size(), 3);
    check_beat("bp_b0", 0, 32'h04030201, 4'hF, 1'b0);
    check_beat("bp_b1", 1, 32'h08070605, 4'hF, 1'b0);
    check_beat("bp_b2", 2, 32'h0C0B0A09, 4'hF, 1'b0);

    // Flush in the cycle A2 pops, FIFO still holding more.
    do_reset();
    push_words(8'hA1, 5);
    intf.m_tready = 1'b1;
    tick();
    intf.flush = 1'b1;
    tick();
    intf.flush = 1'b0;
    tick();
    check("fl_partial_blocked", last_rd_en, 1'b0);
    ticks(8);
    check("fl_partial_beats", rx.size(), 1);
    check_beat("fl_partial", 0, 32'h0000A2A1, 4'h3, 1'b1);
    check("fl_partial_pops", pops, 5);

    // Flush with nothing buffered: no beat, pending clears after one cycle.
    do_reset();
    intf.m_tready = 1'b1;
    intf.flush    = 1'b1;
    tick();
    intf.flush = 1'b0;
    push_words(8'h51, 4);
    tick();
    check("fl_empty_pend_blocks", last_rd_en, 1'b0);
    tick();
    check("fl_empty_pend_cleared", last_rd_en, 1'b1);
    ticks(8);
    check("fl_empty_beats", rx.size(), 1);
    check_beat("fl_empty_next", 0, 32'h54535251, 4'hF, 1'b0);

    // Flush with a full accumulator behind a held slot: full beat with tlast.
    do_reset();
    push_words(8'h01, 8);
    ticks(10);
    check("fl_full_pops", pops, 8);
    intf.flush = 1'b1;
    tick();
    intf.flush = 1'b0;
    tick();
    check("fl_full_no_pop", pops, 8);
    intf.m_tready = 1'b1;
    ticks(10);
    check("fl_full_beats", rx.size(), 2);
    check_beat("fl_full_b0", 0, 32'h04030201, 4'hF, 1'b0);
    check_beat("fl_full_b1", 1, 32'h08070605, 4'hF, 1'b1);

    // Reset mid-operation: cnt=2 and a held beat.
    do_reset();
    push_words(8'h01, 6);
    ticks(6);
    check("rst_pre_tvalid", intf.m_tvalid, 1'b1);
    push_words(8'hB1, 4);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_tvalid", intf.m_tvalid, 1'b0);
    check("rst_async_rd_en", intf.rd_en, 1'b0);
    check("rst_async_tkeep", intf.m_tkeep, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx.delete();
    exp_q.delete();
    pops       = 0;
    prev_stall = 1'b0;
    intf.m_tready = 1'b1;
    ticks(10);
    check("rst_after_beats", rx.size(), 1);
    check_beat("rst_after", 0, 32'hB4B3B2B1, 4'hF, 1'b0);

    // Random traffic, backpressure and flush pulses; stream checked lane by lane.
    do_reset();
    word = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      intf.m_tready = ($urandom_range(0, 9) < 7);
      intf.flush    = ($urandom_range(0, 19) == 0);
      if (q.size() < 4 && $urandom_range(0, 9) < 6) begin
        q.push_back(word);
        word++;
        refresh();
      end
      tick();
      intf.flush = 1'b0;
      score();
    end
    intf.m_tready = 1'b1;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      tick();
      score();
    end
    check("rand_fifo_drained", q.size(), 0);
    ticks(2);
    intf.flush = 1'b1;
    tick();
    intf.flush = 1'b0;
    ticks(10);
    score();
    check("rand_all_words_out", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
